// File: rtl/rom_burst_ctrl.sv
// Weight-memory sequencer: streams a weight image into a single-port memory after reset,
// then serves burst reads through a 2-entry output FIFO with full valid/ready backpressure.
module rom_burst_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_SIZE  = 16,
    parameter int PRELOADED  = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [WORD_SIZE-1:0]  load_data_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic                  reload_i,
    output logic                  loaded_o,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] start_len_i,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    output logic [WORD_SIZE-1:0]  data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wen_o,
    output logic [WORD_SIZE-1:0]  mem_data_o,
    input  logic [WORD_SIZE-1:0]  mem_data_i
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   FULL_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [1:0]            RESET_STATE = (PRELOADED != 0) ? S_IDLE : S_LOAD;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   rem;
    logic                  loaded;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_wen_q;
    logic [WORD_SIZE-1:0]  mem_data_q;

    logic [WORD_SIZE-1:0]  fifo0_data;
    logic [WORD_SIZE-1:0]  fifo1_data;
    logic                  fifo0_last;
    logic                  fifo1_last;
    logic [1:0]            fifo_count;
    logic                  inflight;
    logic                  inflight_last;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [2:0]            occupancy_limit;
    logic [1:0]            fill_idx;

    // A read is only issued if its word is guaranteed a FIFO slot when it returns.
    always_comb begin
        pop             = (fifo_count != 2'd0) && ready_i;
        push            = inflight;
        occupancy       = {1'b0, fifo_count} + {2'b00, inflight};
        occupancy_limit = 3'd2 + {2'b00, pop};
        issue           = (state == S_BURST) && (rem != '0) && (occupancy < occupancy_limit);
        fill_idx        = fifo_count - {1'b0, pop};
    end

    assign load_ready_o  = (state == S_LOAD);
    assign start_ready_o = (state == S_IDLE);
    assign loaded_o      = loaded;
    assign mem_addr_o    = (state == S_BURST) ? rd_ptr : mem_addr_q;
    assign mem_wen_o     = mem_wen_q;
    assign mem_data_o    = mem_data_q;
    assign valid_o       = (fifo_count != 2'd0);
    assign data_o        = fifo0_data;
    assign last_o        = fifo0_last;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state         <= RESET_STATE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rem           <= '0;
            loaded        <= (PRELOADED != 0);
            mem_addr_q    <= '0;
            mem_wen_q     <= 1'b1;
            mem_data_q    <= '0;
            fifo0_data    <= '0;
            fifo1_data    <= '0;
            fifo0_last    <= 1'b0;
            fifo1_last    <= 1'b0;
            fifo_count    <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            mem_wen_q <= 1'b1;
            inflight  <= issue;

            if (issue) begin
                inflight_last <= (rem == REM_ONE);
                rd_ptr        <= rd_ptr + ADDR_ONE;
                rem           <= rem - REM_ONE;
            end

            // Pop shifts the head; the returning word lands in the first free slot after that shift.
            if (pop) begin
                fifo0_data <= fifo1_data;
                fifo0_last <= fifo1_last;
            end
            if (push) begin
                if (fill_idx == 2'd0) begin
                    fifo0_data <= mem_data_i;
                    fifo0_last <= inflight_last;
                end else begin
                    fifo1_data <= mem_data_i;
                    fifo1_last <= inflight_last;
                end
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};

            case (state)
                S_LOAD: begin
                    if (load_valid_i) begin
                        mem_addr_q <= wr_ptr;
                        mem_data_q <= load_data_i;
                        mem_wen_q  <= 1'b0;
                        wr_ptr     <= wr_ptr + ADDR_ONE;
                        if (wr_ptr == LAST_ADDR) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    // The final load write lands in the first IDLE cycle; the image is complete after it.
                    if (!mem_wen_q) begin
                        loaded <= 1'b1;
                    end
                    if (reload_i) begin
                        wr_ptr <= '0;
                        loaded <= 1'b0;
                        state  <= S_LOAD;
                    end else if (start_valid_i) begin
                        rd_ptr <= start_addr_i;
                        rem    <= (start_len_i == '0) ? FULL_LEN : {1'b0, start_len_i};
                        state  <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (pop && fifo0_last) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= RESET_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_ctrl.sv
// Directed bench for rom_burst_ctrl with a 16-word memory: load, bursts, wrap, backpressure,
// reload/start priority, mid-burst reset, and a PRELOADED=1 instance.
module tb_rom_burst_ctrl;

    logic        clk;
    logic        reset_i;

    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic        reload;
    logic        loaded;
    logic [3:0]  start_addr;
    logic [3:0]  start_len;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] data;
    logic        valid;
    logic        last;
    logic        ready;
    logic [3:0]  mem_addr;
    logic        mem_wen;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] mem [16];

    logic        p_load_ready;
    logic        p_loaded;
    logic [3:0]  p_start_addr;
    logic [3:0]  p_start_len;
    logic        p_start_valid;
    logic        p_start_ready;
    logic [15:0] p_data;
    logic        p_valid;
    logic        p_last;
    logic        p_ready;
    logic [3:0]  p_mem_addr;
    logic        p_mem_wen;
    logic [15:0] p_mem_wdata;
    logic [15:0] p_mem_rdata;
    logic [15:0] p_mem [16];

    int vectors;
    int miscompares;
    int p_strobes;

    rom_burst_ctrl #(.ADDR_WIDTH(4), .WORD_SIZE(16), .PRELOADED(0)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .load_data_i(load_data), .load_valid_i(load_valid), .load_ready_o(load_ready),
        .reload_i(reload), .loaded_o(loaded),
        .start_addr_i(start_addr), .start_len_i(start_len),
        .start_valid_i(start_valid), .start_ready_o(start_ready),
        .data_o(data), .valid_o(valid), .last_o(last), .ready_i(ready),
        .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
    );

    rom_burst_ctrl #(.ADDR_WIDTH(4), .WORD_SIZE(16), .PRELOADED(1)) dut_pre (
        .clk_i(clk), .reset_i(reset_i),
        .load_data_i(16'h0000), .load_valid_i(1'b0), .load_ready_o(p_load_ready),
        .reload_i(1'b0), .loaded_o(p_loaded),
        .start_addr_i(p_start_addr), .start_len_i(p_start_len),
        .start_valid_i(p_start_valid), .start_ready_o(p_start_ready),
        .data_o(p_data), .valid_o(p_valid), .last_o(p_last), .ready_i(p_ready),
        .mem_addr_o(p_mem_addr), .mem_wen_o(p_mem_wen), .mem_data_o(p_mem_wdata), .mem_data_i(p_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port memories with registered read, latency 1
    always @(posedge clk) begin
        if (mem_wen === 1'b0) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (p_mem_wen === 1'b0) p_mem[p_mem_addr] <= p_mem_wdata;
        p_mem_rdata <= p_mem[p_mem_addr];
    end

    initial begin
        for (int i = 0; i < 16; i++) p_mem[i] = 16'h0300 + 16'(i);
        p_strobes = 0;
    end

    always @(negedge clk) begin
        if (p_mem_wen !== 1'b1) p_strobes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic load_image(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            load_data  = base + 16'(i);
            load_valid = 1'b1;
            check_output("load_ready", load_ready, 1);
            if (i > 0) begin
                check_output("load_wen", mem_wen, 0);
                check_output("load_addr", mem_addr, i - 1);
                check_output("load_wdata", mem_wdata, base + 16'(i - 1));
            end else begin
                check_output("load_wen_idle", mem_wen, 1);
            end
            tick();
        end
        load_valid = 1'b0;
        load_data  = 16'h0000;
        check_output("final_wen", mem_wen, 0);
        check_output("final_addr", mem_addr, 15);
        check_output("final_wdata", mem_wdata, base + 16'd15);
        check_output("final_load_ready", load_ready, 0);
        check_output("final_loaded_early", loaded, 0);
        tick();
        check_output("loaded", loaded, 1);
        check_output("post_load_wen", mem_wen, 1);
        check_output("post_load_start_ready", start_ready, 1);
        check_output("post_load_load_ready", load_ready, 0);
    endtask

    task automatic run_burst(input logic [3:0] addr, input logic [3:0] len, input logic [15:0] base);
        int          n;
        logic [3:0]  a;
        n           = (len == 4'd0) ? 16 : int'(len);
        ready       = 1'b1;
        start_addr  = addr;
        start_len   = len;
        start_valid = 1'b1;
        check_output("burst_start_ready", start_ready, 1);
        tick();
        start_valid = 1'b0;
        check_output("burst_busy", start_ready, 0);
        check_output("burst_issue0", mem_addr, addr);
        check_output("burst_valid_early", valid, 0);
        tick();
        if (n > 1) begin
            a = addr + 4'd1;
            check_output("burst_issue1", mem_addr, a);
        end
        check_output("burst_valid_early2", valid, 0);
        tick();
        for (int k = 0; k < n; k++) begin
            a = addr + 4'(k);
            check_output("burst_valid", valid, 1);
            check_output("burst_data", data, base + {12'h000, a});
            check_output("burst_last", last, (k == n - 1) ? 1 : 0);
            if (k + 2 < n) begin
                a = addr + 4'(k + 2);
                check_output("burst_issue", mem_addr, a);
            end
            tick();
        end
        check_output("burst_done_valid", valid, 0);
        check_output("burst_done_ready", start_ready, 1);
    endtask

    initial begin
        int          popped;
        int          budget;
        logic [3:0]  a;

        vectors       = 0;
        miscompares   = 0;
        reset_i       = 1'b0;
        load_data     = 16'h0000;
        load_valid    = 1'b0;
        reload        = 1'b0;
        start_addr    = 4'd0;
        start_len     = 4'd0;
        start_valid   = 1'b0;
        ready         = 1'b0;
        p_start_addr  = 4'd0;
        p_start_len   = 4'd0;
        p_start_valid = 1'b0;
        p_ready       = 1'b1;

        tick();
        tick();
        check_output("rst_wen", mem_wen, 1);
        check_output("rst_addr", mem_addr, 0);
        check_output("rst_wdata", mem_wdata, 0);
        check_output("rst_valid", valid, 0);
        check_output("rst_last", last, 0);
        check_output("rst_data", data, 0);
        check_output("rst_start_ready", start_ready, 0);
        check_output("rst_load_ready", load_ready, 1);
        check_output("rst_loaded", loaded, 0);
        check_output("p_rst_start_ready", p_start_ready, 1);
        check_output("p_rst_loaded", p_loaded, 1);
        check_output("p_rst_load_ready", p_load_ready, 0);
        check_output("p_rst_valid", p_valid, 0);
        reset_i = 1'b1;

        // Preloaded instance: burst 2 words from address 2
        p_start_addr  = 4'd2;
        p_start_len   = 4'd2;
        p_start_valid = 1'b1;
        tick();
        p_start_valid = 1'b0;
        check_output("p_busy", p_start_ready, 0);
        tick();
        tick();
        check_output("p_valid0", p_valid, 1);
        check_output("p_data0", p_data, 16'h0302);
        check_output("p_last0", p_last, 0);
        tick();
        check_output("p_data1", p_data, 16'h0303);
        check_output("p_last1", p_last, 1);
        tick();
        check_output("p_done_valid", p_valid, 0);
        check_output("p_done_ready", p_start_ready, 1);

        $display("[TB] loading image 0x100+i");
        load_image(16'h0100);

        $display("[TB] bursts with ready held high");
        run_burst(4'd3, 4'd4, 16'h0100);
        run_burst(4'd14, 4'd4, 16'h0100);
        run_burst(4'd5, 4'd0, 16'h0100);

        $display("[TB] 16-word burst with random backpressure");
        start_addr  = 4'd0;
        start_len   = 4'd0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        popped = 0;
        budget = 0;
        while (popped < 16 && budget < 300) begin
            ready = 1'($urandom_range(0, 1));
            if (valid) begin
                a = 4'(popped);
                check_output("bp_data", data, 16'h0100 + {12'h000, a});
                if (ready) begin
                    popped++;
                    check_output("bp_last", last, (popped == 16) ? 1 : 0);
                end
            end
            tick();
            budget++;
        end
        check_output("bp_words_popped", popped, 16);
        ready = 1'b1;
        check_output("bp_done_valid", valid, 0);
        check_output("bp_done_ready", start_ready, 1);

        $display("[TB] reload and start together");
        reload      = 1'b1;
        start_valid = 1'b1;
        start_addr  = 4'd0;
        start_len   = 4'd1;
        tick();
        reload      = 1'b0;
        start_valid = 1'b0;
        check_output("rl_load_ready", load_ready, 1);
        check_output("rl_loaded", loaded, 0);
        check_output("rl_start_ready", start_ready, 0);
        tick();
        tick();
        tick();
        check_output("rl_no_burst", valid, 0);
        check_output("rl_no_write", mem_wen, 1);

        load_image(16'h0200);
        run_burst(4'd6, 4'd2, 16'h0200);

        $display("[TB] reset mid-burst");
        start_addr  = 4'd0;
        start_len   = 4'd8;
        start_valid = 1'b1;
        ready       = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        check_output("mb_valid", valid, 1);
        check_output("mb_data", data, 16'h0201);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check_output("mb_rst_valid", valid, 0);
        check_output("mb_rst_load_ready", load_ready, 1);
        check_output("mb_rst_start_ready", start_ready, 0);
        check_output("mb_rst_loaded", loaded, 0);
        check_output("mb_rst_addr", mem_addr, 0);
        tick();
        tick();
        check_output("mb_fifo_flushed", valid, 0);

        check_output("p_no_strobes", p_strobes, 0);
        check_output("p_still_loaded", p_loaded, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
